// File: rtl/bus_master_if.sv
// Command/response channel between a requester and bus_master.
// Handshake: a transfer happens on a rising bus_clk where valid & ready are both 1; a raised valid and its payload stay put until that edge.
interface bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wr_data;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;

    // slave: the bus_master side, which accepts commands and returns responses
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wr_data, cmd_be, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rd_data, rsp_err
    );

    // master: the requester issuing commands
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wr_data, cmd_be, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rd_data, rsp_err
    );
endinterface

// File: rtl/bus_master.sv
// Turns one command at a time into a single-cycle rd/wr request on the slave bus and waits, with timeout, for the ack.
// bus_in = {be, wr_data, addr, wr_req, rd_req, reset_l, clk}; bus_out = {irq, wr_ack, rd_ack, rd_data}.
module bus_master #(
    parameter int TIMEOUT       = 255,
    parameter int TMR_W         = 8,
    parameter int BUS_IN_WIDTH  = 72,
    parameter int BUS_OUT_WIDTH = 35
) (
    input  logic                     bus_clk,
    input  logic                     bus_reset_l,
    bus_master_if.slave              cif,
    output logic                     irq,
    output logic [BUS_IN_WIDTH-1:0]  bus_in,
    input  logic [BUS_OUT_WIDTH-1:0] bus_out,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [31:0]      bo_rd_data;
    logic             bo_rd_ack, bo_wr_ack, bo_irq;
    logic             active;

    assign {bo_irq, bo_wr_ack, bo_rd_ack, bo_rd_data} = bus_out;

    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wr_q       <= 1'b0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            be_q       <= 4'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            be_q       <= be_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        be_d       = be_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cif.cmd_valid) begin
                    wr_d    = cif.cmd_write;
                    addr_d  = cif.cmd_addr;
                    data_d  = cif.cmd_wr_data;
                    be_d    = cif.cmd_write ? cif.cmd_be : 4'h0;
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A matching ack is tested before the timeout so it wins a same-cycle race.
                if (wr_q && bo_wr_ack) begin
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (!wr_q && bo_rd_ack) begin
                    rsp_data_d = bo_rd_data;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    timer_d    = TMR_W'(TIMEOUT);
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RESP: begin
                if (cif.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active          = (state_q == REQ) || (state_q == WAIT);
    assign cif.cmd_ready   = (state_q == IDLE) && bus_reset_l;
    assign cif.rsp_valid   = (state_q == RESP);
    assign cif.rsp_rd_data = rsp_data_q;
    assign cif.rsp_err     = rsp_err_q;
    assign irq             = bo_irq;
    assign dbg_state       = state_q;

    assign bus_in = {active ? be_q   : 4'h0,
                     active ? data_q : 32'h0,
                     active ? addr_q : 32'h0,
                     (state_q == REQ) && wr_q,
                     (state_q == REQ) && !wr_q,
                     bus_reset_l,
                     bus_clk};
endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: RAM slave with programmable ack delay at 0x0-0xFFF, stray-ack injector, and a word-memory reference model.
module tb_bus_master;
  localparam int TIMEOUT = 4;
  localparam int BI_W = 72;
  localparam int BO_W = 35;

  logic bus_clk = 1'b0;
  logic bus_reset_l = 1'b0;
  logic irq;
  logic [BI_W-1:0] bus_in;
  logic [BO_W-1:0] bus_out;
  logic [1:0] dbg_state;

  bus_master_if cif();

  bus_master #(.TIMEOUT(TIMEOUT), .TMR_W(3)) dut (
    .bus_clk    (bus_clk),
    .bus_reset_l(bus_reset_l),
    .cif        (cif),
    .irq        (irq),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 bus_clk = ~bus_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // slave side
  logic bi_rd_req, bi_wr_req;
  logic [31:0] bi_addr, bi_data;
  logic [3:0] bi_be;
  assign bi_rd_req = bus_in[2];
  assign bi_wr_req = bus_in[3];
  assign bi_addr   = bus_in[35:4];
  assign bi_data   = bus_in[67:36];
  assign bi_be     = bus_in[71:68];

  logic [31:0] ram [0:1023] = '{default: 32'h0};
  int slave_delay;
  logic s_pend, s_wr, s_rd_ack, s_wr_ack;
  int s_cnt;
  logic [31:0] s_addr, s_data, s_rd_data;
  logic [3:0] s_be;
  logic inj_rd_ack, inj_wr_ack, inj_irq;
  logic [31:0] inj_data;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return m;
  endfunction

  always @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      s_pend <= 1'b0; s_cnt <= 0; s_rd_ack <= 1'b0; s_wr_ack <= 1'b0; s_rd_data <= 32'h0;
    end else begin
      s_rd_ack <= 1'b0;
      s_wr_ack <= 1'b0;
      if (s_pend) begin
        if (s_cnt == 0) begin
          s_pend <= 1'b0;
          if (s_wr) begin
            ram[s_addr[11:2]] <= merge(ram[s_addr[11:2]], s_data, s_be);
            s_wr_ack <= 1'b1;
          end else begin
            s_rd_ack <= 1'b1;
            s_rd_data <= ram[s_addr[11:2]];
          end
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end else if ((bi_rd_req || bi_wr_req) && bi_addr < 32'h1000) begin
        if (slave_delay == 0) begin
          if (bi_wr_req) begin
            ram[bi_addr[11:2]] <= merge(ram[bi_addr[11:2]], bi_data, bi_be);
            s_wr_ack <= 1'b1;
          end else begin
            s_rd_ack <= 1'b1;
            s_rd_data <= ram[bi_addr[11:2]];
          end
        end else begin
          s_pend <= 1'b1; s_cnt <= slave_delay - 1; s_wr <= bi_wr_req;
          s_addr <= bi_addr; s_data <= bi_data; s_be <= bi_be;
        end
      end
    end
  end

  assign bus_out = {inj_irq, s_wr_ack | inj_wr_ack, s_rd_ack | inj_rd_ack,
                    (s_rd_ack ? s_rd_data : 32'h0) | inj_data};

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed word store; ack wait of delay+1 cycles must fit in TIMEOUT.
  logic [31:0] mdl_mem [logic [31:0]];

  function automatic void model_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] be, input int delay,
                                    output logic [31:0] e_data, output logic e_err, output int e_lat);
    logic [31:0] key;
    logic [31:0] word;
    key = {addr[31:2], 2'b00};
    if (addr >= 32'h1000 || delay + 1 > TIMEOUT) begin
      e_err = 1'b1; e_data = 32'h0; e_lat = 2 + TIMEOUT;
      return;
    end
    word = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
    e_err = 1'b0;
    e_lat = 3 + delay;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) word = (word & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
      mdl_mem[key] = word;
      e_data = 32'h0;
    end else begin
      e_data = word;
    end
  endfunction

  // driver
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int delay, input int hold, input bit inj_wrong,
                        output logic [31:0] r_data, output logic r_err, output int lat);
    int n, rd_p, wr_p, p_cyc;
    bit bus_ok, hold_ok;
    slave_delay = delay;
    r_data = 32'hx; r_err = 1'bx; lat = -1;
    @(negedge bus_clk);
    cif.cmd_valid = 1'b1; cif.cmd_write = wr; cif.cmd_addr = addr;
    cif.cmd_wr_data = data; cif.cmd_be = be;
    n = 0;
    while (!cif.cmd_ready && n < 50) begin @(negedge bus_clk); n++; end
    if (!cif.cmd_ready) begin
      check("cmd_accept", 64'(cif.cmd_ready), 64'd1);
      cif.cmd_valid = 1'b0;
      return;
    end
    @(posedge bus_clk);
    #1;
    cif.cmd_valid = 1'b0;
    cif.cmd_addr = $urandom; cif.cmd_wr_data = $urandom; cif.cmd_be = 4'($urandom);
    lat = 0; rd_p = 0; wr_p = 0; p_cyc = -1; bus_ok = 1'b1;
    forever begin
      @(negedge bus_clk);
      lat++;
      if (inj_wrong && lat == 2) begin
        inj_rd_ack = wr; inj_wr_ack = !wr; inj_data = 32'hFFFF_FFFF;
      end else if (lat == 3) begin
        inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_data = 32'h0;
      end
      if (cif.rsp_valid || lat >= 40) break;
      if (bi_rd_req) begin rd_p++; p_cyc = lat; end
      if (bi_wr_req) begin wr_p++; p_cyc = lat; end
      if (bi_addr !== addr || bi_be !== (wr ? be : 4'h0) || (wr && bi_data !== data)) bus_ok = 1'b0;
    end
    inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_data = 32'h0;
    if (!cif.rsp_valid) begin
      check("rsp_wait_bound", 64'(cif.rsp_valid), 64'd1);
      return;
    end
    check("req_pulse", {16'(rd_p), 16'(wr_p), 16'(p_cyc)}, {16'(!wr), 16'(wr), 16'd1});
    check("bus_fields_held", 64'(bus_ok), 64'd1);
    check("bus_idle_in_resp", 64'(|bus_in[71:2]), 64'd0);
    r_data = cif.rsp_rd_data;
    r_err = cif.rsp_err;
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      inj_rd_ack = 1'($urandom); inj_wr_ack = 1'($urandom); inj_data = $urandom;
      @(negedge bus_clk);
      if (!cif.rsp_valid || cif.cmd_ready || cif.rsp_rd_data !== r_data || cif.rsp_err !== r_err)
        hold_ok = 1'b0;
    end
    inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_data = 32'h0;
    if (hold > 0) check("resp_stable", 64'(hold_ok), 64'd1);
    cif.rsp_ready = 1'b1;
    @(posedge bus_clk);
    #1;
    cif.rsp_ready = 1'b0;
    @(negedge bus_clk);
    check("ready_after_rsp", {62'd0, cif.cmd_ready, cif.rsp_valid}, 64'b10);
  endtask

  task automatic txn_check(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input int delay,
                           input int hold, input bit inj_wrong);
    logic [31:0] e_data, r_data;
    logic e_err, r_err;
    int e_lat, lat;
    logic [63:0] exp;
    model_txn(wr, addr, data, be, delay, e_data, e_err, e_lat);
    exp_q.push_back({16'(e_lat), 15'd0, e_err, e_data});
    do_cmd(wr, addr, data, be, delay, hold, inj_wrong, r_data, r_err, lat);
    exp = exp_q.pop_front();
    check(name, {16'(lat), 15'd0, r_err, r_data}, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r_data, m_data;
    logic r_err, m_err;
    int lat, m_lat, n_rsp;

    cif.cmd_valid = 1'b0; cif.cmd_write = 1'b0; cif.cmd_addr = 32'h0;
    cif.cmd_wr_data = 32'h0; cif.cmd_be = 4'h0; cif.rsp_ready = 1'b0;
    inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_irq = 1'b0; inj_data = 32'h0;
    slave_delay = 0;

    vecs.push_back('{1'b1, 32'h100,      32'h12345678, 4'hF, 0, 32'h0,        1'b0, 3});
    vecs.push_back('{1'b0, 32'h100,      32'h0,        4'h0, 0, 32'h12345678, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h100,      32'h000000AA, 4'h1, 0, 32'h0,        1'b0, 3});
    vecs.push_back('{1'b0, 32'h100,      32'h0,        4'h0, 0, 32'h123456AA, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h80000000, 32'h0,        4'h0, 0, 32'h0,        1'b1, 6});
    vecs.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1, 6});
    vecs.push_back('{1'b0, 32'h100,      32'h0,        4'h0, 3, 32'h123456AA, 1'b0, 6});
    vecs.push_back('{1'b1, 32'h104,      32'hDEADBEEF, 4'hC, 2, 32'h0,        1'b0, 5});
    vecs.push_back('{1'b0, 32'h104,      32'h0,        4'h0, 1, 32'hDEAD0000, 1'b0, 4});
    vecs.push_back('{1'b1, 32'h104,      32'h00000055, 4'h1, 3, 32'h0,        1'b0, 6});
    vecs.push_back('{1'b0, 32'h104,      32'h0,        4'h0, 0, 32'hDEAD0055, 1'b0, 3});

    // reset state
    repeat (3) @(negedge bus_clk);
    check("rst_cmd_ready", 64'(cif.cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(cif.rsp_valid), 64'd0);
    check("rst_rsp", {31'd0, cif.rsp_err, cif.rsp_rd_data}, 64'd0);
    check("rst_bus_fields", 64'(|bus_in[71:1]), 64'd0);
    check("clk_field_lo", 64'(bus_in[0]), 64'(bus_clk));
    bus_reset_l = 1'b1;
    #1;
    check("ready_after_release", 64'(cif.cmd_ready), 64'd1);
    check("reset_field", 64'(bus_in[1]), 64'd1);
    @(posedge bus_clk);
    #1;
    check("clk_field_hi", 64'(bus_in[0]), 64'(bus_clk));
    inj_irq = 1'b1;
    #1;
    check("irq_hi", 64'(irq), 64'd1);
    inj_irq = 1'b0;
    #1;
    check("irq_lo", 64'(irq), 64'd0);

    // stray acks while idle
    @(negedge bus_clk);
    inj_rd_ack = 1'b1; inj_wr_ack = 1'b1; inj_data = 32'hCAFE_F00D;
    @(negedge bus_clk);
    inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_data = 32'h0;
    @(negedge bus_clk);
    check("idle_stray_ack", {62'd0, cif.cmd_ready, cif.rsp_valid}, 64'b10);

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      model_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].delay, m_data, m_err, m_lat);
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].delay, 0, 1'b0, r_data, r_err, lat);
      check($sformatf("vec%0d", i), {16'(lat), 15'd0, r_err, r_data},
            {16'(vecs[i].exp_lat), 15'd0, vecs[i].exp_err, vecs[i].exp_data});
    end

    // response held 10 cycles with stray acks, late ack landing in RESP, wrong-type acks in WAIT
    txn_check("hold10_stray", 1'b0, 32'h100, 32'h0, 4'h0, 0, 10, 1'b0);
    txn_check("late_ack_timeout", 1'b0, 32'h104, 32'h0, 4'h0, 4, 2, 1'b0);
    txn_check("wrong_ack_write", 1'b1, 32'h108, 32'h0BADF00D, 4'hF, 2, 0, 1'b1);
    txn_check("wrong_ack_read", 1'b0, 32'h108, 32'h0, 4'h0, 1, 0, 1'b1);

    // reset pulsed during WAIT
    slave_delay = 3;
    @(negedge bus_clk);
    cif.cmd_valid = 1'b1; cif.cmd_write = 1'b0; cif.cmd_addr = 32'h100; cif.cmd_be = 4'hF;
    @(posedge bus_clk);
    #1;
    cif.cmd_valid = 1'b0;
    repeat (2) @(negedge bus_clk);
    check("pre_rst_addr", 64'(bi_addr), 64'h100);
    bus_reset_l = 1'b0;
    #1;
    check("rst_mid_ctrl", {61'd0, cif.cmd_ready, cif.rsp_valid, cif.rsp_err}, 64'd0);
    check("rst_mid_data", 64'(cif.rsp_rd_data), 64'd0);
    check("rst_mid_bus", 64'(|bus_in[71:1]), 64'd0);
    repeat (2) @(negedge bus_clk);
    bus_reset_l = 1'b1;
    n_rsp = 0;
    repeat (10) begin
      @(negedge bus_clk);
      if (cif.rsp_valid || bi_rd_req || bi_wr_req) n_rsp++;
    end
    check("no_rsp_after_rst", 64'(n_rsp), 64'd0);
    check("ready_after_abort", 64'(cif.cmd_ready), 64'd1);
    txn_check("post_rst_read", 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 1'b0);

    // randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      logic wr;
      logic [31:0] addr;
      int delay;
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr = 32'h80000000 | ($urandom & 32'h7FFF_FFFC);
      else addr = 32'h200 + 32'(4 * $urandom_range(0, 7));
      delay = $urandom_range(0, 3);
      txn_check("rand_txn", wr, addr, $urandom, 4'($urandom_range(1, 15)), delay,
                $urandom_range(0, 3), (delay > 0) && ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
